// File: rtl/retire_ctrl.sv
// retire_ctrl: retire-stage sequencer between the ROB head window and the
// retire consumers (freelist, arch map, SQ, LQ).
//
// Each cycle it commits the in-order prefix of completed head entries,
// offers at most one store to the SQ, and closes the group at a mispredicted
// branch or a halt. After a mispredict retires it raises flush for
// FLUSH_CYCLES cycles; after a halt retires it locks until reset.
//
// Optional feature macro: RETIRE_PERF_EN adds perf_retired and
// perf_store_stall saturating counters.
//
// Ports:
//   clock, reset         clock; synchronous active-low reset
//   head_*               per-lane ROB head window fields (lane 0 oldest)
//   store_accepted       SQ commits the offered store this cycle
//   instr_num            number of lanes retiring (also advances ROB head)
//   retire_mask          thermometer mask of retiring lanes
//   T, Told, arch_dest_reg  head fields of retiring lanes (0 elsewhere)
//   is_store, is_load    SQ offer / retiring loads
//   flush, halted        registered sequence outputs
//   perf_retired, perf_store_stall  (RETIRE_PERF_EN only)

// One lane of the retire prefix chain. i_go says every older lane retired
// and did not close the group; i_store_seen says an older lane retired a store.
module retire_ctrl_lane (
  input  logic i_go,
  input  logic i_store_seen,
  input  logic i_valid,
  input  logic i_complete,
  input  logic i_is_store,
  input  logic i_mispred,
  input  logic i_halt,
  input  logic i_store_accepted,
  output logic o_retire,
  output logic o_offer,
  output logic o_go,
  output logic o_store_seen,
  output logic o_mispred_ret,
  output logic o_halt_ret
);
  logic w_cand;

  assign w_cand        = i_go & i_valid & i_complete;
  // Only the first store of the group is offered; a second store stops the chain.
  assign o_offer       = w_cand & i_is_store & ~i_store_seen;
  assign o_retire      = w_cand & (~i_is_store | (~i_store_seen & i_store_accepted));
  assign o_go          = o_retire & ~i_mispred & ~i_halt;
  assign o_store_seen  = i_store_seen | (o_retire & i_is_store);
  assign o_mispred_ret = o_retire & i_mispred;
  assign o_halt_ret    = o_retire & i_halt;
endmodule

module retire_ctrl #(
  parameter  int WAY          = 2,
  parameter  int FLUSH_CYCLES = 1,
  parameter  int PHY_W        = 6,
  parameter  int ARCH_W       = 5,
  localparam int CNT_W        = $clog2(WAY + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WAY-1:0]               head_valid,
  input  logic [WAY-1:0]               head_complete,
  input  logic [WAY-1:0]               head_is_store,
  input  logic [WAY-1:0]               head_is_load,
  input  logic [WAY-1:0]               head_mispred,
  input  logic [WAY-1:0]               head_halt,
  input  logic [WAY-1:0][PHY_W-1:0]    head_T,
  input  logic [WAY-1:0][PHY_W-1:0]    head_Told,
  input  logic [WAY-1:0][ARCH_W-1:0]   head_arch_dest,
  input  logic                         store_accepted,
  output logic [CNT_W-1:0]             instr_num,
  output logic [WAY-1:0]               retire_mask,
  output logic [WAY-1:0][PHY_W-1:0]    T,
  output logic [WAY-1:0][PHY_W-1:0]    Told,
  output logic [WAY-1:0][ARCH_W-1:0]   arch_dest_reg,
  output logic                         is_store,
  output logic [WAY-1:0]               is_load,
  output logic                         flush,
  output logic                         halted
`ifdef RETIRE_PERF_EN
  ,
  output logic [31:0]                  perf_retired,
  output logic [31:0]                  perf_store_stall
`endif
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {NORMAL, STORE_WAIT, FLUSH, HALT} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_fcnt, w_fcnt_next;
  logic          r_flush, r_halted;

  logic [WAY:0]   w_go, w_seen;
  logic [WAY-1:0] w_ret, w_offer, w_mis, w_hlt;
  logic           w_stall, w_mis_ret, w_halt_ret;

  // STORE_WAIT uses the same selection as NORMAL: the pending store sits in
  // lane 0, so it is re-offered every cycle until the SQ accepts it.
  assign w_go[0]   = reset & ((r_state == NORMAL) | (r_state == STORE_WAIT));
  assign w_seen[0] = 1'b0;

  for (genvar i = 0; i < WAY; i++) begin : g_lane
    retire_ctrl_lane u_lane (
      .i_go             (w_go[i]),
      .i_store_seen     (w_seen[i]),
      .i_valid          (head_valid[i]),
      .i_complete       (head_complete[i]),
      .i_is_store       (head_is_store[i]),
      .i_mispred        (head_mispred[i]),
      .i_halt           (head_halt[i]),
      .i_store_accepted (store_accepted),
      .o_retire         (w_ret[i]),
      .o_offer          (w_offer[i]),
      .o_go             (w_go[i+1]),
      .o_store_seen     (w_seen[i+1]),
      .o_mispred_ret    (w_mis[i]),
      .o_halt_ret       (w_hlt[i])
    );
  end

  assign w_stall    = |w_offer & ~store_accepted;
  assign w_mis_ret  = |w_mis;
  assign w_halt_ret = |w_hlt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= NORMAL;
      r_fcnt   <= '0;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_fcnt   <= w_fcnt_next;
      r_flush  <= (w_next == FLUSH);
      r_halted <= (w_next == HALT);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_fcnt_next = r_fcnt;
    case (r_state)
      NORMAL, STORE_WAIT: begin
        // Halt wins over a mispredict on the same lane.
        if (w_halt_ret)      w_next = HALT;
        else if (w_mis_ret) begin
          w_next      = FLUSH;
          w_fcnt_next = CW'(FLUSH_CYCLES);
        end
        else if (w_stall)    w_next = STORE_WAIT;
        else                 w_next = NORMAL;
      end
      FLUSH: begin
        w_fcnt_next = r_fcnt - CW'(1);
        if (r_fcnt <= CW'(1)) w_next = NORMAL;
      end
      HALT:    w_next = HALT;
      default: w_next = NORMAL;
    endcase
  end

  always_comb begin
    retire_mask = w_ret;
    is_store    = |w_offer;
    is_load     = head_is_load & w_ret;
    instr_num   = '0;
    for (int i = 0; i < WAY; i++) begin
      instr_num        = instr_num + CNT_W'(w_ret[i]);
      T[i]             = w_ret[i] ? head_T[i]         : '0;
      Told[i]          = w_ret[i] ? head_Told[i]      : '0;
      arch_dest_reg[i] = w_ret[i] ? head_arch_dest[i] : '0;
    end
  end

  assign flush  = r_flush;
  assign halted = r_halted;

`ifdef RETIRE_PERF_EN
  logic [31:0] r_perf_retired, r_perf_store_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_retired     <= '0;
      r_perf_store_stall <= '0;
    end else begin
      if (r_perf_retired > (32'hFFFF_FFFF - 32'(instr_num))) r_perf_retired <= '1;
      else r_perf_retired <= r_perf_retired + 32'(instr_num);
      if (is_store && !store_accepted && (r_perf_store_stall != '1))
        r_perf_store_stall <= r_perf_store_stall + 32'd1;
    end
  end

  assign perf_retired     = r_perf_retired;
  assign perf_store_stall = r_perf_store_stall;
`endif
endmodule
